prefetch_queue: RTL

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: streams memory beats into a byte queue and
// presents one decoded variable-length instruction record at a time.
module prefetch_queue #(
  parameter int          FETCH_BYTES = 4,
  parameter int          QDEPTH      = 16,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  input  logic                     imem_err,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               ra,
  output logic [3:0]               rb,
  output logic [63:0]              valc,
  output logic [63:0]              valp,
  output logic [63:0]              pc_out,
  output logic                     instr_valid,
  output logic                     imem_error,
  output logic                     hlt
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_FETCH, S_HALTED} state_t;

  state_t        state;
  logic [7:0]    q [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   head_pc, fetch_pc;
  logic          outstanding, drop, err_pending, run;

  logic [7:0]    win [10];
  logic [3:0]    hi, lo, len, pop_len;
  logic          ins_ok, norm_rec, err_rec, fire, to_halt, gnt_fire, app;
  logic [CW-1:0] add_n;

  always_comb begin
    for (int k = 0; k < 10; k++) win[k] = q[rd_ptr + PW'(k)];
  end

  assign hi = win[0][7:4];
  assign lo = win[0][3:0];

  always_comb begin
    ins_ok = 1'b0;
    len    = 4'd1;
    case (hi)
      4'h0, 4'h1, 4'h9: ins_ok = (lo == 4'h0);
      4'h2:             begin len = 4'd2;  ins_ok = (lo <= 4'h6); end
      4'h6:             begin len = 4'd2;  ins_ok = (lo <= 4'h3); end
      4'hA, 4'hB:       begin len = 4'd2;  ins_ok = (lo == 4'h0); end
      4'h7:             begin len = 4'd9;  ins_ok = (lo <= 4'h6); end
      4'h8:             begin len = 4'd9;  ins_ok = (lo == 4'h0); end
      4'h3, 4'h4, 4'h5: begin len = 4'd10; ins_ok = (lo == 4'h0); end
      default:          ;
    endcase
    if (!ins_ok) len = 4'd1;
  end

  // Once a fetch error is pending, any head the queue cannot complete becomes the error record.
  assign norm_rec  = (count != '0) && (count >= CW'(len));
  assign err_rec   = err_pending && !norm_rec;
  assign out_valid = (state == S_FETCH) && (norm_rec || err_rec);

  always_comb begin
    icode       = 4'h0;
    ifun        = 4'h0;
    ra          = 4'h0;
    rb          = 4'h0;
    valc        = 64'h0;
    valp        = 64'h0;
    pc_out      = 64'h0;
    instr_valid = 1'b0;
    imem_error  = 1'b0;
    hlt         = 1'b0;
    if (out_valid && err_rec) begin
      imem_error  = 1'b1;
      instr_valid = 1'b1;
      ra          = 4'hF;
      rb          = 4'hF;
      valp        = head_pc;
      pc_out      = head_pc;
    end else if (out_valid) begin
      icode       = hi;
      ifun        = lo;
      instr_valid = ins_ok;
      hlt         = (win[0] == 8'h00);
      ra          = (len == 4'd2 || len == 4'd10) ? win[1][7:4] : 4'hF;
      rb          = (len == 4'd2 || len == 4'd10) ? win[1][3:0] : 4'hF;
      for (int k = 0; k < 8; k++) begin
        if (len == 4'd10)     valc[8*(7-k) +: 8] = win[k+2];
        else if (len == 4'd9) valc[8*(7-k) +: 8] = win[k+1];
      end
      valp        = head_pc + 64'(len);
      pc_out      = head_pc;
    end
  end

  // out_valid/out_ready: a record transfers on each rising edge where both are high;
  // while out_valid=1 and out_ready=0 the record is held unchanged.
  assign fire     = out_valid && out_ready;
  assign pop_len  = (fire && norm_rec) ? len : 4'd0;
  assign to_halt  = fire && (err_rec || !ins_ok || win[0] == 8'h00);
  assign imem_req = run && (state == S_FETCH) && !outstanding && !err_pending &&
                    (int'(count) + FETCH_BYTES <= QDEPTH);
  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req && imem_gnt;
  assign app       = imem_rvalid && outstanding && !drop && !imem_err && !redirect_valid;
  assign add_n     = app ? CW'(FETCH_BYTES) : '0;

  always_ff @(posedge clk) begin
    if (app) begin
      for (int k = 0; k < FETCH_BYTES; k++) q[wr_ptr + PW'(k)] <= imem_rdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      head_pc     <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      err_pending <= 1'b0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        // A beat granted in this same cycle is still in flight; mark it for discard.
        state       <= S_FETCH;
        count       <= '0;
        rd_ptr      <= wr_ptr;
        head_pc     <= redirect_pc;
        fetch_pc    <= redirect_pc;
        err_pending <= 1'b0;
        outstanding <= gnt_fire;
        drop        <= gnt_fire;
      end else begin
        if (gnt_fire) begin
          fetch_pc    <= fetch_pc + 64'(FETCH_BYTES);
          outstanding <= 1'b1;
          drop        <= 1'b0;
        end else if (imem_rvalid && outstanding) begin
          outstanding <= 1'b0;
          drop        <= 1'b0;
          if (!drop && imem_err) err_pending <= 1'b1;
        end
        if (app) wr_ptr <= wr_ptr + PW'(FETCH_BYTES);
        rd_ptr  <= rd_ptr + PW'(pop_len);
        head_pc <= head_pc + 64'(pop_len);
        count   <= count + add_n - CW'(pop_len);
        if (to_halt) state <= S_HALTED;
      end
    end
  end
endmodule
